// File: rtl/servo_cmd_scheduler.sv
// servo_cmd_scheduler: queued direction/duration commands driving a frame-aligned servo PWM output.
// Define SERVO_SCHED_RAMP_EN to insert one stop frame between direct CW/CCW reversals.
module servo_cmd_scheduler #(
    parameter int FRAME_CYC  = 240000,
    parameter int PULSE_CW   = 12000,
    parameter int PULSE_STOP = 18000,
    parameter int PULSE_CCW  = 24000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_dir,
    input  logic [7:0] cmd_frames,
    output logic       servo,
    output logic       busy,
    output logic       cmd_done
);
    localparam int W    = $clog2(FRAME_CYC + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;

    state_t state, state_nx;
    logic [W-1:0] cnt, width, width_nx;
    logic [7:0] rem, rem_nx;
    logic [1:0] dir, dir_nx;
    logic [CNTW-1:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0] q_dir [FIFO_DEPTH];
    logic [7:0] q_frames [FIFO_DEPTH];
    logic boundary, nonempty, push, pop, last, reversal;

    function automatic logic [W-1:0] pulse_of(input logic [1:0] d);
        return d == 2'b01 ? W'(PULSE_CW) : d == 2'b10 ? W'(PULSE_CCW) : W'(PULSE_STOP);
    endfunction

    assign boundary  = cnt == W'(FRAME_CYC - 1);
    assign nonempty  = count != '0;
    assign cmd_ready = rst_n && enable && (count < CNTW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready && cmd_frames != 8'd0;
    assign last      = state == RUN && boundary && rem == 8'd1;
    assign cmd_done  = enable && last;
    assign busy      = state != IDLE || nonempty;
    assign servo     = rst_n && enable && (cnt < width);

    // Stored directions are normalised (11 -> 00), so only 01/10 pairs xor to 11.
`ifdef SERVO_SCHED_RAMP_EN
    assign reversal = (dir ^ q_dir[rd_ptr]) == 2'b11;
`else
    assign reversal = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        width_nx = width;
        rem_nx   = rem;
        dir_nx   = dir;
        pop      = 1'b0;
        if (boundary) begin
            case (state)
                IDLE: pop = nonempty;
                RAMP: pop = nonempty;
                RUN: begin
                    if (rem != 8'd1) begin
                        rem_nx = rem - 8'd1;
                    end else if (nonempty && !reversal) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = nonempty ? RAMP : IDLE;
                        width_nx = W'(PULSE_STOP);
                        rem_nx   = 8'd0;
                        dir_nx   = nonempty ? dir : 2'b00;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (pop) begin
                state_nx = RUN;
                width_nx = pulse_of(q_dir[rd_ptr]);
                rem_nx   = q_frames[rd_ptr];
                dir_nx   = q_dir[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            state  <= IDLE;
            width  <= W'(PULSE_STOP);
            rem    <= 8'd0;
            dir    <= 2'b00;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt <= boundary ? '0 : cnt + W'(1);
            if (!enable) begin
                state  <= IDLE;
                width  <= W'(PULSE_STOP);
                rem    <= 8'd0;
                dir    <= 2'b00;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                state  <= state_nx;
                width  <= width_nx;
                rem    <= rem_nx;
                dir    <= dir_nx;
                count  <= count + CNTW'(push) - CNTW'(pop);
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_dir[wr_ptr]    <= cmd_dir == 2'b11 ? 2'b00 : cmd_dir;
            q_frames[wr_ptr] <= cmd_frames;
        end
    end
endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// tb_servo_cmd_scheduler: directed frame-by-frame checks of servo widths, handshake, flush and reset.
module tb_servo_cmd_scheduler;
    localparam int FRAME = 40;
    localparam int CW    = 8;
    localparam int STOP  = 12;
    localparam int CCW   = 16;

    logic       clk, rst_n, enable, cmd_valid, cmd_ready, servo, busy, cmd_done;
    logic [1:0] cmd_dir;
    logic [7:0] cmd_frames;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {logic [1:0] d; logic [7:0] f;} cmd_t;
    cmd_t q[$];

    servo_cmd_scheduler #(
        .FRAME_CYC(FRAME), .PULSE_CW(CW), .PULSE_STOP(STOP), .PULSE_CCW(CCW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_frames(cmd_frames), .servo(servo), .busy(busy), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] d, input logic [7:0] f);
        cmd_t c;
        c.d = d;
        c.f = f;
        q.push_back(c);
    endtask

    // Entered at a negedge where the frame counter is 0; returns at the next such negedge.
    task automatic frame(input int drop_at, input int rise_at, output int hi, output int done, output int bz);
        hi = 0;
        done = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i == rise_at) enable = 1'b1;
            if (q.size() > 0 && cmd_ready) begin
                cmd_valid  = 1'b1;
                cmd_dir    = q[0].d;
                cmd_frames = q[0].f;
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            hi += int'(servo);
            done += int'(cmd_done);
            @(posedge clk);
            if (cmd_valid) void'(q.pop_front());
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        bz = int'(busy);
    endtask

`ifdef SERVO_SCHED_RAMP_EN
    localparam int N33 = 10;
    int e33_hi[N33]   = '{STOP, CW, CW, STOP, CCW, STOP, CW, STOP, CCW, STOP};
    int e33_done[N33] = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 0};
`else
    localparam int N33 = 8;
    int e33_hi[N33]   = '{STOP, CW, CW, CCW, STOP, CW, CCW, STOP};
    int e33_done[N33] = '{0, 0, 1, 1, 1, 1, 1, 0};
`endif

    initial begin
        int hi, done, bz;
        clk = 0;
        rst_n = 0;
        enable = 1;
        cmd_valid = 0;
        cmd_dir = 0;
        cmd_frames = 0;
        repeat (3) @(negedge clk);
        check("rst_servo", servo, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", cmd_done, 0);
        rst_n = 1;
        #1;
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        frame(-1, -1, hi, done, bz);
        check("idle_hi", hi, STOP);
        check("idle_done", done, 0);

        add(2'b01, 8'd3);
        frame(-1, -1, hi, done, bz);
        check("cw3_pre_hi", hi, STOP);
        check("cw3_pre_busy", bz, 1);
        for (int k = 0; k < 3; k++) begin
            frame(-1, -1, hi, done, bz);
            check($sformatf("cw3_hi%0d", k), hi, CW);
            check($sformatf("cw3_done%0d", k), done, k == 2 ? 1 : 0);
        end
        frame(-1, -1, hi, done, bz);
        check("cw3_post_hi", hi, STOP);
        check("cw3_post_busy", bz, 0);

        add(2'b01, 8'd2);
        add(2'b10, 8'd1);
        add(2'b00, 8'd1);
        add(2'b01, 8'd1);
        add(2'b10, 8'd1);
        for (int k = 0; k < N33; k++) begin
            frame(-1, -1, hi, done, bz);
            check($sformatf("seq_hi%0d", k), hi, e33_hi[k]);
            check($sformatf("seq_done%0d", k), done, e33_done[k]);
            if (k == 0) check("seq_pending0", q.size(), 1);
            if (k == 1) check("seq_pending1", q.size(), 0);
        end
        check("seq_busy", bz, 0);

`ifdef SERVO_SCHED_RAMP_EN
        add(2'b01, 8'd1);
        add(2'b10, 8'd1);
        frame(-1, -1, hi, done, bz);
        check("ramp_pre", hi, STOP);
        frame(-1, -1, hi, done, bz);
        check("ramp_cw", hi, CW);
        frame(-1, -1, hi, done, bz);
        check("ramp_gap", hi, STOP);
        check("ramp_gap_busy", bz, 1);
        frame(-1, -1, hi, done, bz);
        check("ramp_ccw", hi, CCW);
        frame(-1, -1, hi, done, bz);
        check("ramp_post", hi, STOP);
`endif

        add(2'b10, 8'd10);
        add(2'b01, 8'd5);
        frame(-1, -1, hi, done, bz);
        check("en_pre_hi", hi, STOP);
        for (int k = 0; k < 2; k++) begin
            frame(-1, -1, hi, done, bz);
            check($sformatf("en_ccw_hi%0d", k), hi, CCW);
        end
        frame(5, 20, hi, done, bz);
        check("en_drop_hi", hi, 5);
        check("en_drop_done", done, 0);
        check("en_drop_busy", bz, 0);
        frame(-1, -1, hi, done, bz);
        check("en_after_hi", hi, STOP);
        check("en_after_done", done, 0);
        check("en_after_busy", bz, 0);

        add(2'b01, 8'd0);
        frame(-1, -1, hi, done, bz);
        check("zero_hi", hi, STOP);
        check("zero_done", done, 0);
        check("zero_busy", bz, 0);
        add(2'b01, 8'd5);
        frame(-1, -1, hi, done, bz);
        frame(-1, -1, hi, done, bz);
        check("mid_cw_hi", hi, CW);
        repeat (10) @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_servo", servo, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_servo2", servo, 0);
        check("mid_rst_done", cmd_done, 0);
        rst_n = 1;
        add(2'b10, 8'd1);
        frame(-1, -1, hi, done, bz);
        check("rel_f0_hi", hi, STOP);
        check("rel_f0_done", done, 0);
        frame(-1, -1, hi, done, bz);
        check("rel_f1_hi", hi, CCW);
        check("rel_f1_done", done, 1);
        frame(-1, -1, hi, done, bz);
        check("rel_f2_hi", hi, STOP);
        check("rel_f2_busy", bz, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/servo_cmd_scheduler.md
SERVO_CMD_SCHEDULER -- requirements
Module: servo_cmd_scheduler

Interface
REQ-001 Parameter FRAME_CYC, default 240000, meaning clock cycles per servo PWM frame (20 ms at 12 MHz).
REQ-002 Parameter PULSE_CW, default 12000, meaning high-time cycles for clockwise (1.0 ms).
REQ-003 Parameter PULSE_STOP, default 18000, meaning high-time cycles for stop (1.5 ms).
REQ-004 Parameter PULSE_CCW, default 24000, meaning high-time cycles for counter-clockwise (2.0 ms).
REQ-005 Parameter FIFO_DEPTH, default 4, meaning command queue entries (power of two, minimum 2).
REQ-006 Port clk, in, 1, single system clock; all logic SHALL be synchronous to its rising edge.
REQ-007 Port rst_n, in, 1, reset, asynchronous assert, active-low.
REQ-008 Port enable, in, 1, active-high run enable (toggle switch, pre-synchronised).
REQ-009 Port cmd_valid, in, 1, command offered.
REQ-010 Port cmd_ready, out, 1, command slot available.
REQ-011 Port cmd_dir, in, 2, 00 stop, 01 CW, 10 CCW, 11 treated as stop.
REQ-012 Port cmd_frames, in, 8, command duration in frames.
REQ-013 Port servo, out, 1, servo PWM output.
REQ-014 Port busy, out, 1, a command is executing or queued.
REQ-015 Port cmd_done, out, 1, one-cycle pulse when a command completes.

Function
REQ-016 Frame counter SHALL run 0..FRAME_CYC-1, wrap to 0, free-running whenever rst_n is high, independent of enable.
REQ-017 Frame boundary SHALL be the cycle where the frame counter equals FRAME_CYC-1; pulse width SHALL change only on that edge (no glitched frames).
REQ-018 servo SHALL equal enable AND (frame counter < active pulse width), combinational from registered state.
REQ-019 cmd_ready SHALL equal enable AND (FIFO count < FIFO_DEPTH), derived from registered count only.
REQ-020 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_frames=0 commands SHALL be accepted and discarded (no FIFO write, no cmd_done).
REQ-021 FSM states: IDLE (no active command, pulse PULSE_STOP) and RUN (active command, remaining-frame counter > 0).
REQ-022 At a frame boundary in IDLE with FIFO non-empty: pop head, load its pulse width and frame count, enter RUN; new width applies from frame counter 0.
REQ-023 At a frame boundary in RUN: decrement remaining; at 1->0 assert cmd_done that cycle, then pop next entry in same edge if FIFO non-empty (back-to-back, no gap frame), else enter IDLE with PULSE_STOP.
REQ-024 Push and pop on the same edge SHALL both take effect; count unchanged; an entry pushed on a boundary edge into an empty FIFO SHALL wait until the next boundary.
REQ-025 busy SHALL be 1 in RUN or when FIFO count > 0.
REQ-026 enable deasserted SHALL, on the next edge, flush FIFO, abort the active command without cmd_done, return to IDLE with PULSE_STOP; frame counter continues.

Reset
REQ-027 While rst_n=0: frame counter 0, FIFO empty, state IDLE, pulse width PULSE_STOP, cmd_done 0, busy 0; servo 0 and cmd_ready 0 because enable is ignored during reset.
REQ-028 Reset asserted mid-command SHALL discard all state immediately; after release, the first frame boundary occurs FRAME_CYC cycles later.

Configuration
REQ-029 Macro SERVO_SCHED_RAMP_EN defined: a direct CW->CCW or CCW->CW transition between consecutive commands SHALL insert exactly one PULSE_STOP frame before the new command starts (its frame count not reduced); busy stays 1 during it.
REQ-030 Macro SERVO_SCHED_RAMP_EN undefined: reversals apply at the boundary with no inserted frame; all other behaviour identical.

Verification
REQ-031 Reset, enable=1, no commands -> servo high 18000 cycles of every 240000; busy=0; cmd_ready=1.
REQ-032 Push {CW,3} -> next boundary: 3 frames of 12000-cycle highs, cmd_done pulse on the third frame's boundary, then 18000 highs, busy=0.
REQ-033 Push {CW,2},{CCW,1},{STOP,1},{CW,1},{CCW,1} back-to-back -> 4 accepted, cmd_ready=0 until first pop, fifth accepted after; widths 12000,12000,24000,18000,12000,24000 with no gaps (RAMP_EN undefined).
REQ-034 SERVO_SCHED_RAMP_EN defined, {CW,1} then {CCW,1} -> widths 12000, 18000, 24000.
REQ-035 enable dropped mid-{CCW,10} -> servo 0 next cycle, FIFO empty, no cmd_done; enable re-raised -> 18000 pulses, busy=0.
REQ-036 cmd_frames=0 pushed, and rst_n pulsed low mid-frame -> no cmd_done, busy=0; servo 0 during reset; first boundary exactly 240000 cycles after release.
